// File: rtl/nvram_arbiter.sv
// Arbiter sharing the single-port high-score NVRAM between the CPU, the HPS
// download/upload stream and an internal clear sequencer.
module nvram_arbiter #(
  parameter int              AW      = 10,
  parameter int              DW      = 4,
  parameter logic [DW-1:0]   CLR_VAL = '0
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          ul_rd,
  input  logic [AW-1:0] ul_addr,
  output logic [7:0]    ul_dout,
  output logic          ul_valid,
  input  logic          clr_req,
  output logic          busy,
  output logic          ovf,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  typedef enum logic [2:0] {G_NONE, G_CPU, G_DL, G_UL, G_CLR} gnt_t;

  state_t        r_state;
  state_t        w_state_n;
  gnt_t          w_gnt;

  logic          r_dl_full;
  logic [AW-1:0] r_dl_addr;
  logic [DW-1:0] r_dl_data;
  logic          r_ul_full;
  logic [AW-1:0] r_ul_addr;
  logic          r_clr_q;
  logic [AW-1:0] r_clr_ptr;
  logic          r_ovf;
  logic          r_ul_valid;
  logic [DW-1:0] r_ul_hold;

  logic          w_clr_rise;
  logic          w_dl_avail;
  logic          w_ul_avail;
  logic [AW-1:0] w_dl_addr_sel;
  logic [DW-1:0] w_dl_data_sel;
  logic [AW-1:0] w_ul_addr_sel;
  logic          w_unused_dl_hi;

  assign w_unused_dl_hi = ^dl_data[7:DW];
  assign w_clr_rise     = clr_req & ~r_clr_q;

  // A strobe with its slot empty is served straight from the port (bypass).
  assign w_dl_avail    = r_dl_full | dl_wr;
  assign w_ul_avail    = r_ul_full | ul_rd;
  assign w_dl_addr_sel = r_dl_full ? r_dl_addr : dl_addr;
  assign w_dl_data_sel = r_dl_full ? r_dl_data : dl_data[DW-1:0];
  assign w_ul_addr_sel = r_ul_full ? r_ul_addr : ul_addr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_gnt    = G_NONE;
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (!reset_n)                w_gnt = G_NONE;
    else if (cpu_cs)             w_gnt = G_CPU;
    else if (w_dl_avail)         w_gnt = G_DL;
    else if (w_ul_avail)         w_gnt = G_UL;
    else if (r_state == S_CLEAR) w_gnt = G_CLR;

    case (w_gnt)
      G_CPU: begin
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
        ram_din  = cpu_din;
      end
      G_DL: begin
        ram_addr = w_dl_addr_sel;
        ram_we   = 1'b1;
        ram_din  = w_dl_data_sel;
      end
      G_UL: begin
        ram_addr = w_ul_addr_sel;
      end
      G_CLR: begin
        ram_addr = r_clr_ptr;
        ram_we   = 1'b1;
        ram_din  = CLR_VAL;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:
        if (w_clr_rise && !r_dl_full && !r_ul_full && !dl_wr)
          w_state_n = S_CLEAR;
      S_CLEAR:
        if (w_gnt == G_CLR && r_clr_ptr == {AW{1'b1}})
          w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_q   <= 1'b0;
      r_clr_ptr <= '0;
    end else begin
      r_clr_q <= clr_req;
      if (r_state == S_IDLE && w_state_n == S_CLEAR)
        r_clr_ptr <= '0;
      else if (w_gnt == G_CLR)
        r_clr_ptr <= r_clr_ptr + AW'(1);
    end
  end

  // A full slot that is granted frees and may reload from a coincident strobe.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_full <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= '0;
      r_ul_full <= 1'b0;
      r_ul_addr <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_gnt == G_DL) begin
        if (r_dl_full && dl_wr) begin
          r_dl_addr <= dl_addr;
          r_dl_data <= dl_data[DW-1:0];
        end else begin
          r_dl_full <= 1'b0;
        end
      end else if (dl_wr) begin
        if (r_dl_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_dl_full <= 1'b1;
          r_dl_addr <= dl_addr;
          r_dl_data <= dl_data[DW-1:0];
        end
      end

      if (w_gnt == G_UL) begin
        if (r_ul_full && ul_rd) r_ul_addr <= ul_addr;
        else                    r_ul_full <= 1'b0;
      end else if (ul_rd) begin
        if (r_ul_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_ul_full <= 1'b1;
          r_ul_addr <= ul_addr;
        end
      end
    end
  end

  // Upload data appears with ul_valid and is held afterwards.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ul_valid <= 1'b0;
      r_ul_hold  <= '0;
    end else begin
      r_ul_valid <= (w_gnt == G_UL);
      if (r_ul_valid) r_ul_hold <= ram_dout;
    end
  end

  assign cpu_dout = ram_dout;
  assign ul_valid = r_ul_valid;
  assign ul_dout  = {{(8-DW){1'b0}}, (r_ul_valid ? ram_dout : r_ul_hold)};
  assign busy     = (r_state == S_CLEAR);
  assign ovf      = r_ovf;

endmodule
